riscv_lsu: RTL and testbench

Load/store unit sitting directly downstream of the `riscv` core's execute/memory stage. It owns the byte-addressed data memory and a memory-mapped 8-bit GPIO register. It accepts one RV32I load or store request at a time and moves one byte per clock, big-endian: the word at A is {mem[A], mem[A+1], mem[A+2], mem[A+3]}. It returns a one-cycle `done` pulse carrying either load data or a fault.

---
 rtl/riscv_lsu.sv | 167 ++++++++++++++++
 tb/tb_riscv_lsu.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/riscv_lsu.sv
// rtl/riscv_lsu.sv - byte-serial big-endian RV32I load/store unit with data memory and GPIO register
// Optional build macro RISCV_LSU_MISALIGN_EN: allow misaligned H/W accesses.
module riscv_lsu #(
    parameter int          MEM_BYTES = 1024,
    parameter logic [31:0] GPIO_ADDR = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [7:0]  gpio
);

    localparam int AW = $clog2(MEM_BYTES);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t          state;
    logic            we_r;
    logic [2:0]      f3_r;
    logic [AW-1:0]   addr_r;
    logic [31:0]     wdata_r;
    logic            gpio_r;
    logic [1:0]      idx;
    logic [1:0]      last_r;
    logic [23:0]     asm_r;
    logic [7:0]      mem [MEM_BYTES];

    // Request decode, evaluated on the live inputs at the accept edge
    logic [2:0]  n_bytes;
    logic [1:0]  n_last;
    logic        is_gpio;
    logic        bad_f3;
    logic        bad_store;
    logic        misalign;
    logic        out_range;
    logic        req_fault;
    logic [32:0] end_addr;

    always_comb begin
        n_bytes = 3'd4;
        n_last  = 2'd3;
        case (funct3[1:0])
            2'b00:   begin n_bytes = 3'd1; n_last = 2'd0; end
            2'b01:   begin n_bytes = 3'd2; n_last = 2'd1; end
            default: begin n_bytes = 3'd4; n_last = 2'd3; end
        endcase
        is_gpio   = (addr == GPIO_ADDR);
        if (is_gpio)
            n_last = 2'd0;
        bad_f3    = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
        bad_store = we && (funct3[2:1] == 2'b10);
`ifdef RISCV_LSU_MISALIGN_EN
        misalign  = 1'b0;
`else
        misalign  = ((funct3[1:0] == 2'b01) && addr[0]) ||
                    ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`endif
        end_addr  = {1'b0, addr} + 33'(n_bytes);
        out_range = !is_gpio && (end_addr > 33'(MEM_BYTES));
        req_fault = bad_f3 || bad_store || misalign || out_range;
    end

    // Datapath for the byte currently in flight
    logic [AW-1:0] mem_idx;
    logic [1:0]    shift_sel;
    logic [7:0]    rd_byte;
    logic [7:0]    wr_byte;
    logic [31:0]   full;
    logic [31:0]   load_val;

    always_comb begin
        mem_idx   = addr_r + AW'(idx);
        shift_sel = last_r - idx;
        rd_byte   = gpio_r ? gpio : mem[mem_idx];
        wr_byte   = wdata_r[{shift_sel, 3'b000} +: 8];
        full      = {asm_r, rd_byte};
        case (f3_r)
            3'b000:  load_val = {{24{full[7]}}, full[7:0]};
            3'b001:  load_val = {{16{full[15]}}, full[15:0]};
            3'b100:  load_val = {24'h0, full[7:0]};
            3'b101:  load_val = {16'h0, full[15:0]};
            default: load_val = full;
        endcase
        if (gpio_r)
            load_val = {24'h0, gpio};
    end

    // Memory is never reset; writes stop as soon as the async reset forces IDLE
    always_ff @(posedge clk) begin
        if (state == XFER && we_r && !gpio_r)
            mem[mem_idx] <= wr_byte;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            fault   <= 1'b0;
            rdata   <= 32'h0;
            gpio    <= 8'h0;
            we_r    <= 1'b0;
            f3_r    <= 3'b0;
            addr_r  <= '0;
            wdata_r <= 32'h0;
            gpio_r  <= 1'b0;
            idx     <= 2'd0;
            last_r  <= 2'd0;
            asm_r   <= 24'h0;
        end else begin
            case (state)
                // DONE also samples req so back-to-back accesses cost N+1 cycles
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (req) begin
                        we_r    <= we;
                        f3_r    <= funct3;
                        addr_r  <= addr[AW-1:0];
                        wdata_r <= wdata;
                        gpio_r  <= is_gpio;
                        last_r  <= n_last;
                        idx     <= 2'd0;
                        asm_r   <= 24'h0;
                        fault   <= req_fault;
                        busy    <= 1'b1;
                        if (req_fault) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= XFER;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                XFER: begin
                    asm_r <= {asm_r[15:0], rd_byte};
                    if (gpio_r && we_r)
                        gpio <= wdata_r[7:0];
                    if (idx == last_r) begin
                        state <= DONE;
                        done  <= 1'b1;
                        if (!we_r)
                            rdata <= load_val;
                    end else begin
                        idx <= idx + 2'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// tb/tb_riscv_lsu.sv - directed vector bench for riscv_lsu
module tb_riscv_lsu;

    localparam logic [31:0] GPIO = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        fault;
    logic [7:0]  gpio;

    riscv_lsu #(.MEM_BYTES(1024), .GPIO_ADDR(GPIO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .funct3(funct3),
        .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy),
        .done(done), .fault(fault), .gpio(gpio)
    );

    always #5 clk = ~clk;

    // edges: accept edge to the edge after which done is first seen
    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          edges;
        logic        fault;
        logic        chk_rd;
        logic [31:0] rdata;
        logic [7:0]  gpio;
    } vec_t;

    vec_t vt[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [2:0] f, input logic [31:0] a,
                                input logic [31:0] d, input int e, input logic flt,
                                input logic c, input logic [31:0] r, input logic [7:0] g);
        vec_t v;
        v.we = w; v.f3 = f; v.addr = a; v.wdata = d; v.edges = e;
        v.fault = flt; v.chk_rd = c; v.rdata = r; v.gpio = g;
        return v;
    endfunction

    task automatic drive(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        we = w; funct3 = f; addr = a; wdata = d; req = 1'b1;
    endtask

    task automatic wait_done(output int edges);
        edges = 0;
        while (!done && edges < 12) begin
            @(posedge clk); #1;
            edges++;
        end
        if (!done) edges = -1;
    endtask

    task automatic apply(input vec_t v, input int i);
        int e;
        @(negedge clk);
        drive(v.we, v.f3, v.addr, v.wdata);
        @(posedge clk); #1;
        req = 1'b0;
        wait_done(e);
        chk($sformatf("v%0d latency", i), 32'(e), 32'(v.edges));
        chk($sformatf("v%0d fault", i), {31'h0, fault}, {31'h0, v.fault});
        if (v.chk_rd)
            chk($sformatf("v%0d rdata", i), rdata, v.rdata);
        chk($sformatf("v%0d gpio", i), {24'h0, gpio}, {24'h0, v.gpio});
        @(posedge clk); #1;
        chk($sformatf("v%0d idle", i), {30'h0, busy, done}, 32'h0);
    endtask

    initial begin
        int e;
        int pulses;
        rst_n = 1'b0; req = 1'b0; we = 1'b0; funct3 = 3'b0; addr = 32'h0; wdata = 32'h0;

        vt.push_back(mk(1, 3'b010, 0,    32'h0001F000, 4, 0, 0, 0,            8'h00));
        vt.push_back(mk(0, 3'b010, 0,    0,            4, 0, 1, 32'h0001F000, 8'h00));
        vt.push_back(mk(0, 3'b000, 2,    0,            1, 0, 1, 32'hFFFFFFF0, 8'h00));
        vt.push_back(mk(0, 3'b100, 2,    0,            1, 0, 1, 32'h000000F0, 8'h00));
        vt.push_back(mk(0, 3'b001, 2,    0,            2, 0, 1, 32'hFFFFF000, 8'h00));
        vt.push_back(mk(1, 3'b000, GPIO, 32'h123456A5, 1, 0, 0, 0,            8'hA5));
        vt.push_back(mk(0, 3'b010, GPIO, 0,            1, 0, 1, 32'h000000A5, 8'hA5));
`ifdef RISCV_LSU_MISALIGN_EN
        vt.push_back(mk(0, 3'b001, 1,    0,            2, 0, 1, 32'h000001F0, 8'hA5));
`else
        vt.push_back(mk(0, 3'b001, 1,    0,            0, 1, 1, 32'h000000A5, 8'hA5));
`endif
        vt.push_back(mk(0, 3'b101, 0,    0,            2, 0, 1, 32'h00000001, 8'hA5));
        vt.push_back(mk(1, 3'b001, 4,    32'h0000BEEF, 2, 0, 0, 0,            8'hA5));
        vt.push_back(mk(0, 3'b001, 4,    0,            2, 0, 1, 32'hFFFFBEEF, 8'hA5));
        vt.push_back(mk(0, 3'b011, 0,    0,            0, 1, 1, 32'hFFFFBEEF, 8'hA5));
        vt.push_back(mk(1, 3'b100, GPIO, 32'h0000005A, 0, 1, 1, 32'hFFFFBEEF, 8'hA5));
        vt.push_back(mk(1, 3'b010, 1020, 32'hCAFEF00D, 4, 0, 0, 0,            8'hA5));
        vt.push_back(mk(0, 3'b010, 1020, 0,            4, 0, 1, 32'hCAFEF00D, 8'hA5));
        vt.push_back(mk(0, 3'b101, 1022, 0,            2, 0, 1, 32'h0000F00D, 8'hA5));
        vt.push_back(mk(0, 3'b000, 1024, 0,            0, 1, 1, 32'h0000F00D, 8'hA5));
        vt.push_back(mk(1, 3'b010, 1024, 32'h01020304, 0, 1, 0, 0,            8'hA5));
        vt.push_back(mk(0, 3'b110, 0,    0,            0, 1, 1, 32'h0000F00D, 8'hA5));
        vt.push_back(mk(1, 3'b010, 8,    32'h11223344, 4, 0, 0, 0,            8'hA5));

        repeat (2) @(posedge clk);
        #1;
        chk("reset busy/done/fault", {29'h0, busy, done, fault}, 32'h0);
        chk("reset rdata", rdata, 32'h0);
        chk("reset gpio", {24'h0, gpio}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vt.size(); i++)
            apply(vt[i], i);

        // A req pulse while busy must be ignored
        @(negedge clk);
        drive(0, 3'b010, 0, 0);
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        drive(1, 3'b000, GPIO, 32'h0000005A);
        @(posedge clk); #1;
        req = 1'b0;
        wait_done(e);
        chk("busy-pulse latency", 32'(e + 2), 32'd4);
        chk("busy-pulse rdata", rdata, 32'h0001F000);
        pulses = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        chk("busy-pulse extra done", 32'(pulses), 32'd0);
        chk("busy-pulse gpio", {24'h0, gpio}, 32'h000000A5);

        // Reset asserted after two transfer edges of a store
        @(negedge clk);
        drive(1, 3'b010, 8, 32'hDEADBEEF);
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort busy/done", {30'h0, busy, done}, 32'h0);
        chk("abort rdata/fault", {rdata[30:0], fault}, 32'h0);
        chk("abort gpio", {24'h0, gpio}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(mk(0, 3'b010, 8, 0, 4, 0, 1, 32'hDEAD3344, 8'h00), 100);

        // Back-to-back: next request accepted on the edge leaving DONE
        @(negedge clk);
        drive(0, 3'b100, 2, 0);
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        chk("b2b first done", {31'h0, done}, 32'h1);
        chk("b2b first rdata", rdata, 32'h000000F0);
        drive(0, 3'b100, 0, 0);
        @(posedge clk); #1;
        req = 1'b0;
        chk("b2b accepted busy/done", {30'h0, busy, done}, 32'h2);
        @(posedge clk); #1;
        chk("b2b second done", {31'h0, done}, 32'h1);
        chk("b2b second rdata", rdata, 32'h00000000);
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
